int_isq_wakeup_n: RTL and testbench



---
 rtl/int_isq_wakeup_n.sv | 164 ++++++++++++++++
 tb/tb_int_isq_wakeup_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_isq_wakeup_n.sv
// Integer issue queue with per-source multi-port wakeup, age-matrix oldest-ready
// select, valid/ready issue port and ROB-id based squash of younger entries.
module int_isq_wakeup_n #(
  parameter int DEPTH     = 8,
  parameter int NUM_WB    = 2,
  parameter int PREG_W    = 6,
  parameter int ROBID_W   = 7,
  parameter int PAYLOAD_W = 124
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [PAYLOAD_W-1:0]         enq_payload,
  input  logic [ROBID_W-1:0]           enq_robid,
  input  logic [PREG_W-1:0]            enq_prs1,
  input  logic [PREG_W-1:0]            enq_prs2,
  input  logic                         enq_rdy1,
  input  logic                         enq_rdy2,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [PAYLOAD_W-1:0]         deq_payload,
  output logic [ROBID_W-1:0]           deq_robid,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0]            wb_need_to_wb,
  input  logic [NUM_WB*PREG_W-1:0]     wb_prd,
  input  logic                         flush_valid,
  input  logic [ROBID_W-1:0]           flush_robid,
  output logic [$clog2(DEPTH):0]       isq_count,
  output logic                         intisq_can_enq
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rdy1_q, rdy2_q;
  logic [DEPTH-1:0]     hit1, hit2;
  logic [DEPTH-1:0]     cand, sel, flush_kill;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [ROBID_W-1:0]   robid_q   [DEPTH];
  logic [PREG_W-1:0]    prs1_q    [DEPTH];
  logic [PREG_W-1:0]    prs2_q    [DEPTH];
  // age_q[i][j] set means entry i is older than entry j.
  logic [DEPTH-1:0]     age_q [DEPTH];
  logic [DEPTH-1:0]     age_d [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     free_idx;
  logic                 enq_hit1, enq_hit2;
  logic                 enq_fire, deq_fire;

  function automatic logic is_younger(input logic [ROBID_W-1:0] a,
                                      input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1]) return a[ROBID_W-2:0] > b[ROBID_W-2:0];
    else                              return a[ROBID_W-2:0] < b[ROBID_W-2:0];
  endfunction

  // Every port is compared against every stored source and the incoming sources.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit1     = '0;
    hit2     = '0;
    enq_hit1 = 1'b0;
    enq_hit2 = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && wb_need_to_wb[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_prd[p*PREG_W +: PREG_W] == prs1_q[i]) hit1[i] = 1'b1;
          if (wb_prd[p*PREG_W +: PREG_W] == prs2_q[i]) hit2[i] = 1'b1;
        end
        if (wb_prd[p*PREG_W +: PREG_W] == enq_prs1) enq_hit1 = 1'b1;
        if (wb_prd[p*PREG_W +: PREG_W] == enq_prs2) enq_hit2 = 1'b1;
      end
    end
  end

  always_comb begin
    logic blocked;
    cand        = valid_q & rdy1_q & rdy2_q;
    sel         = '0;
    deq_payload = '0;
    deq_robid   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && age_q[j][i]) blocked = 1'b1;
      end
      sel[i] = cand[i] && !blocked;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        deq_payload = deq_payload | payload_q[i];
        deq_robid   = deq_robid | robid_q[i];
      end
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign enq_ready      = (count_q < CNT_W'(DEPTH)) && !flush_valid;
  assign intisq_can_enq = enq_ready;
  assign deq_valid      = (|cand) && !flush_valid;
  assign enq_fire       = enq_valid && enq_ready;
  assign deq_fire       = deq_valid && deq_ready;
  assign isq_count      = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      flush_kill[i] = flush_valid && valid_q[i] && is_younger(robid_q[i], flush_robid);
    end
    valid_d = valid_q & ~flush_kill;
    if (deq_fire) valid_d = valid_d & ~sel;
    if (enq_fire) valid_d[free_idx] = 1'b1;

    age_d = age_q;
    if (enq_fire) begin
      for (int i = 0; i < DEPTH; i++) age_d[i][free_idx] = valid_q[i];
      age_d[free_idx] = '0;
    end

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(valid_d[i]);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // NOTE: entry storage is not reset; it is qualified by valid_q and rewritten on every enqueue.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_q[i] <= rdy1_q[i] | hit1[i];
      rdy2_q[i] <= rdy2_q[i] | hit2[i];
    end
    if (enq_fire) begin
      payload_q[free_idx] <= enq_payload;
      robid_q[free_idx]   <= enq_robid;
      prs1_q[free_idx]    <= enq_prs1;
      prs2_q[free_idx]    <= enq_prs2;
      rdy1_q[free_idx]    <= enq_rdy1 | enq_hit1;
      rdy2_q[free_idx]    <= enq_rdy2 | enq_hit2;
    end
  end

endmodule

// File: tb/tb_int_isq_wakeup_n.sv
// Scoreboard bench for int_isq_wakeup_n: stimulus pushes expected issue order,
// a negedge monitor pops and compares on every accepted issue.
module tb_int_isq_wakeup_n;

  localparam int DEPTH = 8, NUM_WB = 2, PREG_W = 6, ROBID_W = 7, PAYLOAD_W = 124;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enq_valid = 1'b0;
  logic                     enq_ready;
  logic [PAYLOAD_W-1:0]     enq_payload = '0;
  logic [ROBID_W-1:0]       enq_robid = '0;
  logic [PREG_W-1:0]        enq_prs1 = '0, enq_prs2 = '0;
  logic                     enq_rdy1 = 1'b0, enq_rdy2 = 1'b0;
  logic                     deq_valid;
  logic                     deq_ready = 1'b1;
  logic [PAYLOAD_W-1:0]     deq_payload;
  logic [ROBID_W-1:0]       deq_robid;
  logic [NUM_WB-1:0]        wb_valid = '0, wb_need_to_wb = '0;
  logic [NUM_WB*PREG_W-1:0] wb_prd = '0;
  logic                     flush_valid = 1'b0;
  logic [ROBID_W-1:0]       flush_robid = '0;
  logic [$clog2(DEPTH):0]   isq_count;
  logic                     intisq_can_enq;

  typedef struct {
    logic [ROBID_W-1:0]   robid;
    logic [PAYLOAD_W-1:0] payload;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int_isq_wakeup_n #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .PREG_W(PREG_W),
                     .ROBID_W(ROBID_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_robid(enq_robid), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_rdy1(enq_rdy1), .enq_rdy2(enq_rdy2),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_payload(deq_payload),
    .deq_robid(deq_robid),
    .wb_valid(wb_valid), .wb_need_to_wb(wb_need_to_wb), .wb_prd(wb_prd),
    .flush_valid(flush_valid), .flush_robid(flush_robid),
    .isq_count(isq_count), .intisq_can_enq(intisq_can_enq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] pl(input logic [ROBID_W-1:0] r);
    return {r, 110'h0, r};
  endfunction

  task automatic push(input logic [ROBID_W-1:0] r);
    exp_t e;
    e.robid   = r;
    e.payload = pl(r);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_enq(input logic [ROBID_W-1:0] r, input logic [PREG_W-1:0] p1,
                         input logic [PREG_W-1:0] p2, input logic r1, input logic r2);
    enq_valid   = 1'b1;
    enq_robid   = r;
    enq_payload = pl(r);
    enq_prs1    = p1;
    enq_prs2    = p2;
    enq_rdy1    = r1;
    enq_rdy2    = r2;
  endtask

  task automatic enq(input logic [ROBID_W-1:0] r, input logic [PREG_W-1:0] p1,
                     input logic [PREG_W-1:0] p2, input logic r1, input logic r2);
    set_enq(r, p1, p2, r1, r2);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wb(input logic v0, input logic [PREG_W-1:0] p0,
                    input logic v1, input logic [PREG_W-1:0] p1);
    wb_valid      = {v1, v0};
    wb_need_to_wb = {v1, v0};
    wb_prd        = {p1, p0};
  endtask

  task automatic wb_clear();
    wb_valid      = '0;
    wb_need_to_wb = '0;
    wb_prd        = '0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    check(name, 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && deq_valid && deq_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got robid %0h expected no issue", deq_robid);
      end else begin
        e = exp_q.pop_front();
        check("issue_robid", 128'(deq_robid), 128'(e.robid));
        check("issue_payload", 128'(deq_payload), 128'(e.payload));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_deq_valid", 128'(deq_valid), 128'(0));
    check("rst_count", 128'(isq_count), 128'(0));
    check("rst_enq_ready", 128'(enq_ready), 128'(1));
    check("rst_can_enq", 128'(intisq_can_enq), 128'(1));
    check("rst_deq_robid", 128'(deq_robid), 128'(0));
    check("rst_deq_payload", 128'(deq_payload), 128'(0));

    // Three ready entries issue in order on consecutive cycles
    push(7'd5); push(7'd6); push(7'd7);
    enq(7'd5, 6'd0, 6'd0, 1'b1, 1'b1);
    enq(7'd6, 6'd0, 6'd0, 1'b1, 1'b1);
    enq(7'd7, 6'd0, 6'd0, 1'b1, 1'b1);
    drain("t1_drain");
    check("t1_count", 128'(isq_count), 128'(0));

    // A waits on prs1=10, B ready; need_to_wb=0 must not wake A
    enq(7'd10, 6'd10, 6'd0, 1'b0, 1'b1);
    wb_valid = 2'b01; wb_need_to_wb = 2'b00; wb_prd = {6'd0, 6'd10};
    push(7'd11); push(7'd10);
    enq(7'd11, 6'd0, 6'd0, 1'b1, 1'b1);
    wb(1'b1, 6'd10, 1'b1, 6'd10);
    check("t2_b_first", 128'(deq_robid), 128'(7'd11));
    tick();
    wb_clear();
    drain("t2_drain");

    // Same-cycle bypass on both sources
    wb(1'b1, 6'd12, 1'b1, 6'd13);
    push(7'd20);
    enq(7'd20, 6'd12, 6'd13, 1'b0, 1'b0);
    wb_clear();
    check("t3_bypass_valid", 128'(deq_valid), 128'(1));
    check("t3_bypass_robid", 128'(deq_robid), 128'(7'd20));
    drain("t3_drain");

    // Fill all slots, none ready
    for (int i = 0; i < DEPTH; i++) enq(7'(48 + i), 6'(30 + i), 6'd0, 1'b0, 1'b1);
    check("t4_full_enq_ready", 128'(enq_ready), 128'(0));
    check("t4_full_can_enq", 128'(intisq_can_enq), 128'(0));
    check("t4_full_count", 128'(isq_count), 128'(8));
    check("t4_full_deq_valid", 128'(deq_valid), 128'(0));
    set_enq(7'h50, 6'd40, 6'd0, 1'b0, 1'b1);
    wb(1'b1, 6'd33, 1'b0, 6'd0);
    push(7'h33);
    tick();
    wb_clear();
    check("t4_deq_slot3", 128'(deq_valid), 128'(1));
    check("t4_full_deq_no_enq", 128'(enq_ready), 128'(0));
    tick();
    check("t4_count_after_deq", 128'(isq_count), 128'(7));
    check("t4_enq_ready_again", 128'(enq_ready), 128'(1));
    tick();
    enq_valid = 1'b0;
    check("t4_refill_count", 128'(isq_count), 128'(8));
    check("t4_refill_enq_ready", 128'(enq_ready), 128'(0));
    // New entry must be youngest: older 0x34 woken together with it issues first
    wb(1'b1, 6'd34, 1'b1, 6'd40);
    push(7'h34); push(7'h50);
    tick();
    wb_clear();
    drain("t4_age_drain");
    push(7'h30); push(7'h31); push(7'h32); push(7'h35); push(7'h36); push(7'h37);
    wb(1'b1, 6'd30, 1'b1, 6'd31); tick();
    wb(1'b1, 6'd32, 1'b1, 6'd35); tick();
    wb(1'b1, 6'd36, 1'b1, 6'd37); tick();
    wb_clear();
    drain("t4_drain");
    check("t4_count_empty", 128'(isq_count), 128'(0));

    // Wrap-aware flush at 0x7F
    deq_ready = 1'b0;
    enq(7'h7E, 6'd50, 6'd0, 1'b0, 1'b1);
    enq(7'h7F, 6'd0, 6'd0, 1'b1, 1'b1);
    enq(7'h00, 6'd52, 6'd0, 1'b0, 1'b1);
    enq(7'h01, 6'd0, 6'd0, 1'b1, 1'b1);
    check("t5_hold_valid", 128'(deq_valid), 128'(1));
    check("t5_hold_robid", 128'(deq_robid), 128'(7'h7F));
    flush_valid = 1'b1;
    flush_robid = 7'h7F;
    deq_ready   = 1'b1;
    set_enq(7'h60, 6'd0, 6'd0, 1'b1, 1'b1);
    wb(1'b1, 6'd50, 1'b1, 6'd52);
    #1;
    check("t5_flush_deq_valid", 128'(deq_valid), 128'(0));
    check("t5_flush_enq_ready", 128'(enq_ready), 128'(0));
    check("t5_flush_can_enq", 128'(intisq_can_enq), 128'(0));
    check("t5_flush_count", 128'(isq_count), 128'(4));
    push(7'h7E); push(7'h7F);
    tick();
    flush_valid = 1'b0;
    enq_valid   = 1'b0;
    wb_clear();
    check("t5_count_after", 128'(isq_count), 128'(2));
    drain("t5_drain");
    check("t5_count_empty", 128'(isq_count), 128'(0));

    // Reset mid-operation overrides enqueue, dequeue and wakeup
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) enq(7'(16 + i), 6'd0, 6'd0, 1'b1, 1'b1);
    enq(7'h14, 6'd60, 6'd0, 1'b0, 1'b1);
    check("t6_pre_valid", 128'(deq_valid), 128'(1));
    check("t6_pre_count", 128'(isq_count), 128'(5));
    reset     = 1'b1;
    deq_ready = 1'b1;
    wb(1'b1, 6'd60, 1'b0, 6'd0);
    set_enq(7'h15, 6'd0, 6'd0, 1'b1, 1'b1);
    tick();
    reset     = 1'b0;
    enq_valid = 1'b0;
    wb_clear();
    check("t6_deq_valid", 128'(deq_valid), 128'(0));
    check("t6_count", 128'(isq_count), 128'(0));
    check("t6_enq_ready", 128'(enq_ready), 128'(1));
    check("t6_deq_robid", 128'(deq_robid), 128'(0));
    check("t6_deq_payload", 128'(deq_payload), 128'(0));
    repeat (3) tick();
    check("t6_still_empty", 128'(deq_valid), 128'(0));
    check("t6_still_count", 128'(isq_count), 128'(0));

    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
